frame_peak_rms_accum: RTL and testbench
=======================================

// Module: frame_peak_rms_accum
// PURPOSE
//  Consumes the sample stream at the skid_buffer m-side. Per frame (beats delimited by s_last),
//  computes peak |x|, sum of x^2 and beat count. Emits one result beat per frame to the
//  RMS/report stage; the sqrt/divide is done downstream.
// PARAMETERS
//  DATA_W         32    input stream width; matches skid_buffer DATA_W
//  SAMPLE_W       16    signed sample width, taken from s_data[SAMPLE_W-1:0]
//  MAX_FRAME_LEN  1024  largest legal frame; sets CNT_W and ACC_W
//  (derived) CNT_W = $clog2(MAX_FRAME_LEN+1); ACC_W = 2*SAMPLE_W + $clog2(MAX_FRAME_LEN)
// PORTS
//  clk       in   1         single clock, all logic posedge
//  rst_n     in   1         asynchronous, active-low reset
//  s_valid   in   1         input beat valid
//  s_ready   out  1         input beat accept
//  s_data    in   DATA_W    sample in [SAMPLE_W-1:0]; upper bits ignored
//  s_last    in   1         final beat of frame
//  m_valid   out  1         result valid
//  m_ready   in   1         result accept
//  m_peak    out  SAMPLE_W  max |x| over frame (unsigned)
//  m_sumsq   out  ACC_W     sum of x^2 over frame (unsigned)
//  m_count   out  CNT_W     beats in frame (saturating)
//  m_ovf     out  1         frame exceeded MAX_FRAME_LEN
// BEHAVIOUR
//  - Reset (async assert, sync release): state=ACC, all accumulators 0, m_valid=0.
//    m_peak/m_sumsq/m_count/m_ovf are 0.
//  - Handshake: a beat transfers when valid&&ready on posedge. m_valid is held until m_ready.
//    m_* outputs are stable while m_valid&&!m_ready. s_ready never depends on s_valid.
//  - FSM, 2 states:
//    ACC: s_ready=1, m_valid=0. Each accepted beat updates peak/sumsq/count.
//         Accepted beat with s_last -> RESULT. The final values include that beat.
//    RESULT: s_ready=0, m_valid=1. When m_ready=1: go to ACC and clear the accumulators
//         in the same edge.
//  - Latency: m_valid rises 1 cycle after the last beat's handshake.
//    Throughput: at least 1 bubble per frame (s_ready low during RESULT).
//  - Arithmetic:
//    |x| is computed in SAMPLE_W-bit unsigned, so |-2^(SAMPLE_W-1)| = 2^(SAMPLE_W-1) exactly.
//    x^2 uses a signed multiply, zero-extended to ACC_W.
//    peak updates only on strict greater-than.
//  - Boundary:
//    Single-beat frame is legal. Zero-length frames cannot occur.
//    When count would exceed MAX_FRAME_LEN: count holds at MAX_FRAME_LEN, sumsq saturates
//    at all-ones, peak keeps updating, m_ovf=1 for that frame. ovf clears with the accumulators.
//  - Reset mid-frame or mid-RESULT discards the partial frame/result. No output beat is produced.
//  - s_valid with X while rst_n=1 is a bench error. No X may appear on s_ready or m_valid.
// STRUCTURE
//  - audio_pkg holds:
//    SAMPLE_W default constant
//    typedef enum logic {ACC, RESULT} accum_state_t
//    typedef struct packed {peak, sumsq, count, ovf} frame_result_t
//  - Sub-module sample_abs_sq: combinational x -> {|x|, x^2}. It is the single place to add
//    a pipeline register later.
//  - Top holds the FSM, the accumulators and the result register.
// TESTING
//  - Bench reuses the skid_buffer bench style:
//    queue-based scoreboard
//    assertions: m-side stable while stalled, s_ready low in RESULT, no X on handshakes
//    random m_ready staller
//  - T1: frame {3,-4,5}, m_ready=1 -> m_peak=5, m_sumsq=50, m_count=3, m_ovf=0, m_valid
//    1 cycle after the last handshake.
//  - T2: single beat -32768 (0x8000) with last -> peak=0x8000, sumsq=0x4000_0000, count=1.
//  - T3: frame {2,2}, then m_ready=0 for 4 cycles -> outputs frozen, s_ready=0, the next
//    frame's beats are held. Then frame {1,1} -> peak=1, sumsq=2, count=2.
//  - T4: MAX_FRAME_LEN+2 beats of value 1 -> count=MAX_FRAME_LEN, sumsq=MAX_FRAME_LEN, ovf=1.
//    The next frame {1} gives ovf=0.
//  - T5: rst_n pulsed low after 2 beats of a frame, then frame {7} -> only one result:
//    peak=7, sumsq=49, count=1.
//  - T6: s_data=0xFFFF_0002 (upper bits set) -> treated as 2: peak=2, sumsq=4.

Source files
------------

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
//   Shared constants and types for the frame statistics path.
//   - *_DEF constants: default widths/limits used by the interfaces, the
//     accumulator top level and anything that models its results.
//   - accum_state_t: accumulator FSM state.
//   - frame_result_t: one per-frame result beat at the default widths.
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int DATA_W_DEF        = 32;
  localparam int SAMPLE_W_DEF      = 16;
  localparam int MAX_FRAME_LEN_DEF = 1024;
  localparam int CNT_W_DEF         = $clog2(MAX_FRAME_LEN_DEF + 1);
  localparam int ACC_W_DEF         = 2 * SAMPLE_W_DEF + $clog2(MAX_FRAME_LEN_DEF);

  typedef enum logic {
    ACC    = 1'b0,
    RESULT = 1'b1
  } accum_state_t;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] peak;
    logic [ACC_W_DEF-1:0]    sumsq;
    logic [CNT_W_DEF-1:0]    count;
    logic                    ovf;
  } frame_result_t;

endpackage

// File: rtl/frame_peak_rms_accum_if.sv
// ---------------------------------------------------------------------------
// Stream interfaces around frame_peak_rms_accum.
//   sample_stream_if : sample beats from the skid_buffer m-side
//     s_valid/s_ready handshake, s_data (sample in the low bits), s_last
//   frame_result_if  : one result beat per frame to the RMS/report stage
//     m_valid/m_ready handshake, m_peak, m_sumsq, m_count, m_ovf
//   master drives valid and payload, slave drives ready.
// ---------------------------------------------------------------------------
interface sample_stream_if
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

interface frame_result_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF
) ();
  localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
  localparam int ACC_W = 2 * SAMPLE_W + $clog2(MAX_FRAME_LEN);

  logic                m_valid;
  logic                m_ready;
  logic [SAMPLE_W-1:0] m_peak;
  logic [ACC_W-1:0]    m_sumsq;
  logic [CNT_W-1:0]    m_count;
  logic                m_ovf;

  modport master (output m_valid, output m_peak, output m_sumsq, output m_count,
                  output m_ovf, input m_ready);
  modport slave  (input  m_valid, input  m_peak, input  m_sumsq, input  m_count,
                  input  m_ovf, output m_ready);
endinterface

// File: rtl/frame_peak_rms_accum_abs_sq.sv
// ---------------------------------------------------------------------------
// sample_abs_sq
//   Combinational x -> {|x|, x^2} for one signed sample. This is the one
//   place to insert a pipeline register if timing ever needs it.
//   sample_i : signed sample, SAMPLE_W bits
//   abs_o    : |x| as SAMPLE_W-bit unsigned
//   sq_o     : x*x as 2*SAMPLE_W-bit unsigned
// ---------------------------------------------------------------------------
module sample_abs_sq #(
  parameter int SAMPLE_W = 16
) (
  input  logic [SAMPLE_W-1:0]   sample_i,
  output logic [SAMPLE_W-1:0]   abs_o,
  output logic [2*SAMPLE_W-1:0] sq_o
);

  logic signed [2*SAMPLE_W-1:0] x_ext;
  logic signed [2*SAMPLE_W-1:0] sq_s;

  // Negating in SAMPLE_W bits maps the most negative value onto itself, and
  // read as unsigned that bit pattern is exactly its magnitude.
  assign abs_o = sample_i[SAMPLE_W-1] ? (~sample_i + SAMPLE_W'(1)) : sample_i;

  assign x_ext = {{SAMPLE_W{sample_i[SAMPLE_W-1]}}, sample_i};
  assign sq_s  = x_ext * x_ext;
  assign sq_o  = $unsigned(sq_s);

endmodule

// File: rtl/frame_peak_rms_accum.sv
// ---------------------------------------------------------------------------
// frame_peak_rms_accum
//   Per frame (beats delimited by s_last) accumulates peak |x|, sum of x^2
//   and beat count, then presents one result beat. sqrt/divide happen
//   downstream.
//   clk   : single clock, posedge
//   rst_n : asynchronous active-low reset (release synchronised upstream)
//   s_if  : sample stream slave  (s_valid, s_ready, s_data, s_last)
//   m_if  : result stream master (m_valid, m_ready, m_peak, m_sumsq,
//           m_count, m_ovf)
// ---------------------------------------------------------------------------
module frame_peak_rms_accum
  import audio_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  sample_stream_if.slave s_if,
  frame_result_if.master m_if
);

  localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
  localparam int ACC_W = 2 * SAMPLE_W + $clog2(MAX_FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_LEN);

  accum_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0]   peak_q, peak_d;
  logic [ACC_W-1:0]      sumsq_q, sumsq_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic [SAMPLE_W-1:0]   x_abs;
  logic [2*SAMPLE_W-1:0] x_sq;
  logic [ACC_W:0]        sum_wide;
  logic                  unused_data;

  sample_abs_sq #(.SAMPLE_W(SAMPLE_W)) u_abs_sq (
    .sample_i (s_if.s_data[SAMPLE_W-1:0]),
    .abs_o    (x_abs),
    .sq_o     (x_sq)
  );

  // Bits above the sample are ignored by design.
  assign unused_data = ^s_if.s_data;

  // One extra bit catches a carry out so the sum can clamp to all-ones.
  assign sum_wide = {1'b0, sumsq_q} + (ACC_W + 1)'(x_sq);

  // Handshake outputs depend on state only, never on s_valid.
  assign s_if.s_ready = (state_q == ACC);
  assign m_if.m_valid = (state_q == RESULT);

  // The accumulators double as the result register: nothing can change them
  // while in RESULT because s_ready is low, so the outputs hold under stall.
  assign m_if.m_peak  = peak_q;
  assign m_if.m_sumsq = sumsq_q;
  assign m_if.m_count = count_q;
  assign m_if.m_ovf   = ovf_q;

  always_comb begin
    // NOTE: every _d takes its current value first, so any path that does
    // not assign it simply holds state instead of inferring a latch.
    state_d = state_q;
    peak_d  = peak_q;
    sumsq_d = sumsq_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      ACC: begin
        if (s_if.s_valid) begin
          if (x_abs > peak_q) peak_d = x_abs;
          // Past MAX_FRAME_LEN the count and sum freeze and the frame is
          // flagged; the peak keeps tracking.
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
            sumsq_d = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
          end
          if (s_if.s_last) state_d = RESULT;
        end
      end
      RESULT: begin
        if (m_if.m_ready) begin
          state_d = ACC;
          peak_d  = '0;
          sumsq_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of the order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      peak_q  <= '0;
      sumsq_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      sumsq_q <= sumsq_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_frame_peak_rms_accum.sv
// ---------------------------------------------------------------------------
// tb_frame_peak_rms_accum
//   Self-checking bench for frame_peak_rms_accum. A behavioural model turns
//   each accepted frame into its expected result (max |x|, sum of squares of
//   the first MAX_FRAME_LEN beats, clamped count, overflow flag) and queues
//   it; one compare process checks the result side every cycle against the
//   queue head, plus handshake invariants. Directed frames pin the model with
//   hand-computed values; a randomized phase uses a random m_ready staller.
// ---------------------------------------------------------------------------
module tb_frame_peak_rms_accum;
  import audio_pkg::*;

  localparam int MAX    = MAX_FRAME_LEN_DEF;
  localparam int BUDGET = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_stream_if #(.DATA_W(DATA_W_DEF)) s_if ();
  frame_result_if #(.SAMPLE_W(SAMPLE_W_DEF), .MAX_FRAME_LEN(MAX)) m_if ();

  frame_peak_rms_accum #(
    .DATA_W        (DATA_W_DEF),
    .SAMPLE_W      (SAMPLE_W_DEF),
    .MAX_FRAME_LEN (MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (s_if),
    .m_if  (m_if)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int n_results = 0;
  int mr_mode   = 0;  // 0: m_ready=1, 1: random, 2: m_ready=0

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic frame_result_t model_frame(input int beats[$]);
    frame_result_t   r;
    longint unsigned sum = 0;
    longint unsigned acc_max = (64'd1 << ACC_W_DEF) - 1;
    int              pk = 0;
    int              n = beats.size();
    foreach (beats[i]) begin
      int a;
      a = (beats[i] < 0) ? -beats[i] : beats[i];
      if (a > pk) pk = a;
      if (i < MAX) sum += longint'(beats[i]) * longint'(beats[i]);
    end
    if (sum > acc_max) sum = acc_max;
    r.peak  = SAMPLE_W_DEF'(pk);
    r.sumsq = ACC_W_DEF'(sum);
    r.count = CNT_W_DEF'((n > MAX) ? MAX : n);
    r.ovf   = (n > MAX);
    return r;
  endfunction

  int            cur_frame[$];
  frame_result_t exp_q[$];

  // ---------------- compare process ----------------
  // Sampled on negedge: inputs move at posedge+1, so the values seen here are
  // exactly the ones the next posedge will act on.
  bit            lat_pending = 0;
  bit            prev_stall  = 0;
  frame_result_t prev_out;

  always @(negedge clk) begin
    frame_result_t      act;
    logic signed [15:0] xs;
    act.peak  = m_if.m_peak;
    act.sumsq = m_if.m_sumsq;
    act.count = m_if.m_count;
    act.ovf   = m_if.m_ovf;
    if (!rst_n) begin
      cur_frame.delete();
      exp_q.delete();
      lat_pending = 0;
      prev_stall  = 0;
      check("rst_m_valid", m_if.m_valid, 1'b0);
    end else begin
      check("x_handshake", $isunknown({s_if.s_ready, m_if.m_valid}), 1'b0);
      check("s_ready_vs_m_valid", s_if.s_ready, !m_if.m_valid);
      if (lat_pending) check("m_valid_latency", m_if.m_valid, 1'b1);
      lat_pending = 0;
      if (prev_stall) begin
        check("stall_hold_valid", m_if.m_valid, 1'b1);
        check("stall_hold_data", act, prev_out);
      end
      if (m_if.m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1'b1, 1'b0);
        end else begin
          check("res_peak",  m_if.m_peak,  exp_q[0].peak);
          check("res_sumsq", m_if.m_sumsq, exp_q[0].sumsq);
          check("res_count", m_if.m_count, exp_q[0].count);
          check("res_ovf",   m_if.m_ovf,   exp_q[0].ovf);
          if (m_if.m_ready) begin
            void'(exp_q.pop_front());
            n_results++;
          end
        end
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_out   = act;
      if (s_if.s_valid && s_if.s_ready) begin
        xs = s_if.s_data[15:0];
        cur_frame.push_back(int'(xs));
        if (s_if.s_last) begin
          exp_q.push_back(model_frame(cur_frame));
          cur_frame.delete();
          lat_pending = 1;
        end
      end
    end
  end

  // ---------------- m_ready staller ----------------
  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = ($urandom_range(0, 2) != 0);
        default: m_if.m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- drivers (all start at posedge+1) ----------------
  task automatic send_beat(input logic [31:0] d, input bit last);
    int waited = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = last;
    @(negedge clk);
    while (!(s_if.s_ready && rst_n)) begin
      waited++;
      if (waited > BUDGET) begin
        check("s_ready_timeout", waited, BUDGET);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    s_if.s_data  = $urandom();
  endtask

  task automatic send_frame(input logic [31:0] vals[$], input bit gaps);
    foreach (vals[i]) begin
      send_beat(vals[i], i == vals.size() - 1);
      if (gaps) repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_result(input string tag, input int pk, input longint sq,
                             input int cnt, input bit ovf);
    int waited = 0;
    @(negedge clk);
    while (!m_if.m_valid && waited <= BUDGET) begin
      waited++;
      @(negedge clk);
    end
    if (!m_if.m_valid) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
    end else begin
      check({tag, "_latency"}, waited, 0);
      check({tag, "_peak"},  m_if.m_peak,  pk);
      check({tag, "_sumsq"}, m_if.m_sumsq, sq);
      check({tag, "_count"}, m_if.m_count, cnt);
      check({tag, "_ovf"},   m_if.m_ovf,   ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_m_valid"}, m_if.m_valid, 1'b0);
    check({tag, "_s_ready"}, s_if.s_ready, 1'b1);
    check({tag, "_peak"},    m_if.m_peak,  '0);
    check({tag, "_sumsq"},   m_if.m_sumsq, '0);
    check({tag, "_count"},   m_if.m_count, '0);
    check({tag, "_ovf"},     m_if.m_ovf,   1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] q[$];
    int          base;
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    s_if.s_data  = '0;
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: {3,-4,5}
    mr_mode = 0;
    q = '{32'd3, 32'hFFFF_FFFC, 32'd5};
    send_frame(q, 0);
    wait_result("t1", 5, 50, 3, 0);

    // T2: most negative sample
    q = '{32'h0000_8000};
    send_frame(q, 0);
    wait_result("t2", 'h8000, 'h4000_0000, 1, 0);

    // T3: stall the {2,2} result while the next frame waits
    mr_mode = 2;
    q = '{32'd2, 32'd2};
    send_frame(q, 0);
    wait_result("t3a", 2, 8, 2, 0);
    q = '{32'd1, 32'd1};
    fork
      send_frame(q, 0);
    join_none
    repeat (4) begin
      @(negedge clk);
      check("t3_stall_m_valid", m_if.m_valid, 1'b1);
      check("t3_stall_s_ready", s_if.s_ready, 1'b0);
      check("t3_stall_peak",    m_if.m_peak,  2);
      check("t3_stall_sumsq",   m_if.m_sumsq, 8);
    end
    mr_mode = 0;
    wait fork;
    wait_result("t3b", 1, 2, 2, 0);

    // T4: overflow frame then a normal frame
    q.delete();
    repeat (MAX + 2) q.push_back(32'd1);
    send_frame(q, 0);
    wait_result("t4a", 1, MAX, MAX, 1);
    q = '{32'd1};
    send_frame(q, 0);
    wait_result("t4b", 1, 1, 1, 0);

    // T5: reset mid-frame discards the partial frame
    send_beat(32'd9, 0);
    send_beat(32'hFFFF_FFF4, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset("t5_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = n_results;
    q = '{32'd7};
    send_frame(q, 0);
    wait_result("t5", 7, 49, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_result_count", n_results - base, 1);

    // T6: upper data bits ignored
    q = '{32'hFFFF_0002};
    send_frame(q, 0);
    wait_result("t6", 2, 4, 1, 0);

    // Randomized frames with a random m_ready staller
    mr_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 12);
      q.delete();
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 7))
          0:       q.push_back(32'h0000_8000);
          1:       q.push_back(32'h1234_7FFF);
          default: q.push_back($urandom());
        endcase
      end
      send_frame(q, 1);
    end
    mr_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
